// File: rtl/elevator_pkg.sv
// ---------------------------------------------------------------------------
// elevator_pkg
//   Shared types and helpers for the SCAN elevator controller.
//   - state_t    : controller FSM states
//   - AC_*       : motor command encodings driven on AC
//   - idx_width  : max(1, clog2(n)), used for floor index and timer widths
//   - above_mask / below_mask : 16-bit floor masks strictly above/below f
// ---------------------------------------------------------------------------
package elevator_pkg;

  localparam int MAX_FLOORS = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MOVE_UP,
    ST_MOVE_DOWN,
    ST_DOOR_OPEN,
    ST_ESTOP
  } state_t;

  localparam logic [1:0] AC_STOP = 2'b00;
  localparam logic [1:0] AC_UP   = 2'b01;
  localparam logic [1:0] AC_DOWN = 2'b10;

  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Floors strictly above f. For f = 15 every bit shifts out.
  function automatic logic [MAX_FLOORS-1:0] above_mask(input logic [3:0] f);
    logic [MAX_FLOORS-1:0] m;
    m = 16'hFFFF << f;
    return m << 1;
  endfunction

  // Floors strictly below f. For f = 0 the mask is empty.
  function automatic logic [MAX_FLOORS-1:0] below_mask(input logic [3:0] f);
    return (16'h0001 << f) - 16'h0001;
  endfunction

endpackage

// File: rtl/elevator_scan_ctrl_if.sv
// ---------------------------------------------------------------------------
// elevator_scan_ctrl_if
//   Button/status bundle between the building (master) and the controller
//   (slave).
//   F, U, D : cabin, hall-up and hall-down buttons (one bit per floor)
//   hold    : door hold / obstruction
//   estop   : emergency stop
//   AC      : motor command (00 stop, 01 up, 10 down)
//   DISP    : current floor index
//   open    : door open
//   pend    : per-floor pending-request lamps
// ---------------------------------------------------------------------------
interface elevator_scan_ctrl_if
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS = 8
);
  localparam int FW = idx_width(NUM_FLOORS);

  logic [NUM_FLOORS-1:0] F;
  logic [NUM_FLOORS-1:0] U;
  logic [NUM_FLOORS-1:0] D;
  logic                  hold;
  logic                  estop;
  logic [1:0]            AC;
  logic [FW-1:0]         DISP;
  logic                  open;
  logic [NUM_FLOORS-1:0] pend;

  modport master (
    output F, U, D, hold, estop,
    input  AC, DISP, open, pend
  );

  modport slave (
    input  F, U, D, hold, estop,
    output AC, DISP, open, pend
  );
endinterface

// File: rtl/elevator_timer.sv
// ---------------------------------------------------------------------------
// elevator_timer
//   Down-counter used for both travel and door dwell timing.
//   load   : start a LIMIT-clock interval (count <= LIMIT-1)
//   clear  : abort and return to 0 (priority over load)
//   expire : count is 0; sampled on an edge this ends the interval
//   clk, rst_n : clock, asynchronous active-low reset
// ---------------------------------------------------------------------------
module elevator_timer #(
  parameter int WIDTH = 2,
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic clear,
  output logic expire
);
  localparam logic [WIDTH-1:0] RELOAD = WIDTH'(LIMIT - 1);

  logic [WIDTH-1:0] count;

  // NOTE: clocked state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              count <= '0;
    else if (clear)          count <= '0;
    else if (load)           count <= RELOAD;
    else if (count != '0)    count <= count - 1'b1;
  end

  assign expire = (count == '0);
endmodule

// File: rtl/elevator_scan_ctrl.sv
// ---------------------------------------------------------------------------
// elevator_scan_ctrl
//   SCAN (elevator-algorithm) car controller. Latches cabin/hall requests,
//   keeps moving in the current direction while requests lie ahead, opens
//   the door at requested floors, and honours hold and emergency stop.
//   clk   : clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : button inputs and AC/DISP/open/pend outputs (slave side)
//   All outputs are decoded from registers only.
// ---------------------------------------------------------------------------
module elevator_scan_ctrl
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS    = 8,
  parameter int TRAVEL_CYCLES = 4,
  parameter int DOOR_CYCLES   = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  elevator_scan_ctrl_if.slave  bus
);
  localparam int FW = idx_width(NUM_FLOORS);
  localparam int TW = idx_width(TRAVEL_CYCLES);
  localparam int DW = idx_width(DOOR_CYCLES);

  localparam logic [NUM_FLOORS-1:0] ONE        = NUM_FLOORS'(1);
  localparam logic [NUM_FLOORS-1:0] TOP_BIT    = ONE << (NUM_FLOORS - 1);
  localparam logic [NUM_FLOORS-1:0] BOTTOM_BIT = ONE;

  state_t                state;
  logic [FW-1:0]         disp;
  logic                  dir_up;
  logic [NUM_FLOORS-1:0] car_req, up_req, dn_req;

  logic travel_expire, dwell_expire;
  logic travel_load, dwell_load;

  // Decision signals derived from registered state and current buttons.
  logic [NUM_FLOORS-1:0] pend_vec, here_mask, latch_mask, clr_mask;
  logic [NUM_FLOORS-1:0] car_next, up_next, dn_next;
  logic [15:0]           pend16;
  logic [3:0]            disp4, arr4;
  logic [FW-1:0]         arr_floor;
  logic here, above, below, idle_up, idle_down, call_here;
  logic in_door, moving, arrive, arr_open, arr_more;
  logic open_idle, open_arr, door_entry;

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned, which would otherwise infer a latch.
  always_comb begin
    pend_vec   = car_req | up_req | dn_req;
    pend16     = 16'(pend_vec);
    disp4      = 4'(disp);
    here_mask  = ONE << disp;
    in_door    = (state == ST_DOOR_OPEN);
    moving     = (state == ST_MOVE_UP) || (state == ST_MOVE_DOWN);
    // The floor the door stands at does not latch; a press there only
    // extends the dwell instead.
    latch_mask = in_door ? ~here_mask : '1;
    call_here  = |((bus.F | (bus.U & ~TOP_BIT) | (bus.D & ~BOTTOM_BIT)) & here_mask);

    here  = pend16[disp4];
    above = |(pend16 & above_mask(disp4));
    below = |(pend16 & below_mask(disp4));
    // Requests both ways: keep the last direction (SCAN).
    idle_up   = !here && above && (dir_up || !below);
    idle_down = !here && below && !idle_up;

    arr_floor = (state == ST_MOVE_UP) ? disp + 1'b1 : disp - 1'b1;
    arr4      = 4'(arr_floor);
    arr_open  = pend16[arr4];
    arr_more  = (state == ST_MOVE_UP) ? |(pend16 & above_mask(arr4))
                                      : |(pend16 & below_mask(arr4));
    arrive    = moving && travel_expire;

    open_idle  = (state == ST_IDLE) && here;
    open_arr   = arrive && arr_open;
    door_entry = !bus.estop && (open_idle || open_arr);
    clr_mask   = '0;
    if (door_entry) clr_mask = open_idle ? here_mask : (ONE << arr_floor);

    car_next = (car_req | (bus.F & latch_mask)) & ~clr_mask;
    up_next  = (up_req  | (bus.U & ~TOP_BIT & latch_mask)) & ~clr_mask;
    dn_next  = (dn_req  | (bus.D & ~BOTTOM_BIT & latch_mask)) & ~clr_mask;

    travel_load = !bus.estop &&
                  (((state == ST_IDLE) && (idle_up || idle_down)) ||
                   (arrive && !arr_open && arr_more));
    dwell_load  = door_entry || (!bus.estop && in_door && (bus.hold || call_here));
  end

  // NOTE: request registers are plain flops, so reset clears them all;
  // a pending call must not survive a reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      disp    <= '0;
      dir_up  <= 1'b1;
      car_req <= '0;
      up_req  <= '0;
      dn_req  <= '0;
    end else begin
      car_req <= car_next;
      up_req  <= up_next;
      dn_req  <= dn_next;
      if (bus.estop) begin
        state <= ST_ESTOP;
      end else begin
        case (state)
          ST_IDLE: begin
            if (here) begin
              state <= ST_DOOR_OPEN;
            end else if (idle_up) begin
              state  <= ST_MOVE_UP;
              dir_up <= 1'b1;
            end else if (idle_down) begin
              state  <= ST_MOVE_DOWN;
              dir_up <= 1'b0;
            end
          end
          ST_MOVE_UP, ST_MOVE_DOWN: begin
            if (travel_expire) begin
              disp <= arr_floor;
              // Nothing further ahead cannot occur in practice; stopping
              // keeps DISP inside the shaft regardless.
              if (arr_open)       state <= ST_DOOR_OPEN;
              else if (!arr_more) state <= ST_IDLE;
            end
          end
          ST_DOOR_OPEN: begin
            if (dwell_expire && !bus.hold && !call_here) state <= ST_IDLE;
          end
          ST_ESTOP: state <= ST_IDLE;
          default:  state <= ST_IDLE;
        endcase
      end
    end
  end

  elevator_timer #(.WIDTH(TW), .LIMIT(TRAVEL_CYCLES)) u_travel (
    .clk    (clk),
    .rst_n  (reset),
    .load   (travel_load),
    .clear  (bus.estop),
    .expire (travel_expire)
  );

  elevator_timer #(.WIDTH(DW), .LIMIT(DOOR_CYCLES)) u_dwell (
    .clk    (clk),
    .rst_n  (reset),
    .load   (dwell_load),
    .clear  (bus.estop),
    .expire (dwell_expire)
  );

  assign bus.AC   = (state == ST_MOVE_UP)   ? AC_UP   :
                    (state == ST_MOVE_DOWN) ? AC_DOWN : AC_STOP;
  assign bus.DISP = disp;
  assign bus.open = in_door;
  assign bus.pend = pend_vec;
endmodule

// File: tb/tb_elevator_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_elevator_scan_ctrl
//   Self-checking bench for elevator_scan_ctrl with NUM_FLOORS=8,
//   TRAVEL_CYCLES=4, DOOR_CYCLES=3. Inputs change 1 time unit after a
//   rising edge; outputs are compared at that same point.
// ---------------------------------------------------------------------------
module tb_elevator_scan_ctrl;
  import elevator_pkg::*;

  localparam int NF = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  elevator_scan_ctrl_if #(.NUM_FLOORS(NF)) bus ();

  elevator_scan_ctrl #(
    .NUM_FLOORS(NF), .TRAVEL_CYCLES(4), .DOOR_CYCLES(3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [7:0] f, u, d;
    logic       hold, estop;
    logic [1:0] ac;
    logic [2:0] disp;
    logic       open;
    logic [7:0] pend;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add_vec(input logic [7:0] f, u, d, input logic hold, estop,
                         input logic [1:0] ac, input logic [2:0] disp,
                         input logic open, input logic [7:0] pend);
    vec_t v;
    v.f = f; v.u = u; v.d = d; v.hold = hold; v.estop = estop;
    v.ac = ac; v.disp = disp; v.open = open; v.pend = pend;
    vecs.push_back(v);
  endtask

  task automatic pulse_reset();
    #2 reset = 1'b0;
    #1;
    check("rst_ac",   bus.AC,   AC_STOP);
    check("rst_disp", bus.DISP, 0);
    check("rst_open", bus.open, 0);
    check("rst_pend", bus.pend, 0);
    #2 reset = 1'b1;
  endtask

  initial begin
    int  n;
    bit  found, saw_down, moved;

    reset = 1'b0;
    bus.F = '0; bus.U = '0; bus.D = '0; bus.hold = 1'b0; bus.estop = 1'b0;

    // Floor 0 hall-up call, then cabin call to floor 3, then ignored bits.
    add_vec(8'h01, 0, 0, 0, 0, AC_STOP, 0, 0, 8'h01);
    for (int i = 0; i < 3; i++) add_vec(0, 0, 0, 0, 0, AC_STOP, 0, 1, 8'h00);
    add_vec(0, 0, 0, 0, 0, AC_STOP, 0, 0, 8'h00);
    vecs[0].u = 8'h01; vecs[0].f = 8'h00;
    add_vec(8'h08, 0, 0, 0, 0, AC_STOP, 0, 0, 8'h08);
    for (int i = 0; i < 4; i++) add_vec(0, 0, 0, 0, 0, AC_UP, 0, 0, 8'h08);
    for (int i = 0; i < 4; i++) add_vec(0, 0, 0, 0, 0, AC_UP, 1, 0, 8'h08);
    for (int i = 0; i < 4; i++) add_vec(0, 0, 0, 0, 0, AC_UP, 2, 0, 8'h08);
    for (int i = 0; i < 3; i++) add_vec(0, 0, 0, 0, 0, AC_STOP, 3, 1, 8'h00);
    for (int i = 0; i < 2; i++) add_vec(0, 0, 0, 0, 0, AC_STOP, 3, 0, 8'h00);
    add_vec(0, 8'h80, 8'h01, 0, 0, AC_STOP, 3, 0, 8'h00);
    add_vec(0, 0, 0, 0, 0, AC_STOP, 3, 0, 8'h00);

    #2;
    check("init_ac",   bus.AC,   AC_STOP);
    check("init_disp", bus.DISP, 0);
    check("init_open", bus.open, 0);
    check("init_pend", bus.pend, 0);
    step();
    reset = 1'b1;

    foreach (vecs[i]) begin
      bus.F = vecs[i].f; bus.U = vecs[i].u; bus.D = vecs[i].d;
      bus.hold = vecs[i].hold; bus.estop = vecs[i].estop;
      step();
      check($sformatf("v%0d_ac", i),   bus.AC,   vecs[i].ac);
      check($sformatf("v%0d_disp", i), bus.DISP, vecs[i].disp);
      check($sformatf("v%0d_open", i), bus.open, vecs[i].open);
      check($sformatf("v%0d_pend", i), bus.pend, vecs[i].pend);
    end
    bus.F = '0; bus.U = '0; bus.D = '0;

    // Moving up to 6, down call at 1 raised passing floor 2.
    pulse_reset();
    bus.F = 8'h40; step(); bus.F = '0;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      if (bus.DISP == 2) found = 1;
    end
    check("b_reach2", found, 1);
    bus.D = 8'h02; step(); bus.D = '0;
    check("b_pend_both", bus.pend, 8'h42);
    found = 0; saw_down = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      step();
      if (bus.AC == AC_DOWN) saw_down = 1;
      if (bus.open) found = 1;
    end
    check("b_open6_seen", found, 1);
    check("b_open6_disp", bus.DISP, 6);
    check("b_no_early_down", saw_down, 0);
    check("b_pend_after6", bus.pend, 8'h02);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (bus.AC == AC_DOWN) found = 1;
    end
    check("b_goes_down", found, 1);
    found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      step();
      if (bus.open) found = 1;
    end
    check("b_open1_seen", found, 1);
    check("b_open1_disp", bus.DISP, 1);
    check("b_pend_empty", bus.pend, 0);

    // Door hold at floor 4.
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      step();
      if (!bus.open) found = 1;
    end
    check("c_door1_closed", found, 1);
    bus.F = 8'h10; step(); bus.F = '0;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      if (bus.open) found = 1;
    end
    check("c_open4_seen", found, 1);
    check("c_open4_disp", bus.DISP, 4);
    bus.hold = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("c_hold%0d_open", i), bus.open, 1);
    end
    bus.hold = 1'b0;
    step(); check("c_after1_open", bus.open, 1);
    step(); check("c_after2_open", bus.open, 1);
    step(); check("c_after3_open", bus.open, 0);

    // Emergency stop between floors 1 and 2.
    pulse_reset();
    bus.F = 8'h04; step(); bus.F = '0;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (bus.DISP == 1) found = 1;
    end
    check("d_reach1", found, 1);
    step();
    bus.estop = 1'b1; step();
    check("d_estop_ac",   bus.AC,   AC_STOP);
    check("d_estop_disp", bus.DISP, 1);
    check("d_estop_open", bus.open, 0);
    bus.F = 8'h20; step(); bus.F = '0; step();
    check("d_estop_pend", bus.pend, 8'h24);
    check("d_estop_ac2",  bus.AC,   AC_STOP);
    bus.estop = 1'b0; step();
    check("d_release_ac", bus.AC, AC_STOP);
    n = 0; found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      n++;
      if (bus.DISP == 2) found = 1;
    end
    check("d_resume_cycles", n, 5);
    check("d_open2", bus.open, 1);

    // Reset during dwell at floor 5 with a call pending at 7.
    bus.F = 8'h80; step(); bus.F = '0;
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      step();
      if (!bus.open) found = 1;
    end
    check("e_door2_closed", found, 1);
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      if (bus.open) found = 1;
    end
    check("e_open5_seen", found, 1);
    check("e_open5_disp", bus.DISP, 5);
    check("e_pend7", bus.pend[7], 1);
    pulse_reset();
    moved = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (bus.AC != AC_STOP || bus.open) moved = 1;
    end
    check("e_no_motion", moved, 0);
    check("e_disp_final", bus.DISP, 0);
    check("e_pend_final", bus.pend, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
